// File: rtl/adc_xy_sample_stream.sv
// XY ADC front end: registers the raw pin buses, suppresses repeated points and
// buffers the survivors in a show-ahead FIFO with a saturating lost-sample counter.
module adc_xy_sample_stream #(
  parameter int ADC_DATA_BITS = 10,
  parameter int FIFO_DEPTH    = 4,
  parameter int DEDUP         = 1,
  parameter int DROP_CNT_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [ADC_DATA_BITS-1:0] adc_x_io,
  input  logic [ADC_DATA_BITS-1:0] adc_y_io,
  input  logic                     clr_stats,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ADC_DATA_BITS-1:0] m_x,
  output logic [ADC_DATA_BITS-1:0] m_y,
  output logic [DROP_CNT_BITS-1:0] dropped_cnt,
  output logic                     overflow
);
  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_BITS:0]      DEPTH_C = (PTR_BITS+1)'(FIFO_DEPTH);
  localparam logic [DROP_CNT_BITS-1:0] CNT_MAX = {DROP_CNT_BITS{1'b1}};

  logic [ADC_DATA_BITS-1:0] r_x_io;
  logic [ADC_DATA_BITS-1:0] r_y_io;
  logic                     r_s1_valid;
  logic [ADC_DATA_BITS-1:0] r_last_x;
  logic [ADC_DATA_BITS-1:0] r_last_y;
  logic                     r_have_last;
  logic [ADC_DATA_BITS-1:0] r_mem_x [FIFO_DEPTH];
  logic [ADC_DATA_BITS-1:0] r_mem_y [FIFO_DEPTH];
  logic [PTR_BITS-1:0]      r_wr_ptr;
  logic [PTR_BITS-1:0]      r_rd_ptr;
  logic [PTR_BITS:0]        r_count;
  logic [DROP_CNT_BITS-1:0] r_dropped;
  logic                     r_overflow;

  logic w_valid;
  logic w_pop;
  logic w_dup;
  logic w_space;
  logic w_push;
  logic w_drop;

  // Pin capture stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_io     <= {ADC_DATA_BITS{1'b0}};
      r_y_io     <= {ADC_DATA_BITS{1'b0}};
      r_s1_valid <= 1'b0;
    end else begin
      r_x_io     <= adc_x_io;
      r_y_io     <= adc_y_io;
      r_s1_valid <= enable;
    end
  end

  // Push/drop/discard decision; a full FIFO still has room when it pops this cycle
  always_comb begin
    w_valid = 1'b0;
    w_pop   = 1'b0;
    w_dup   = 1'b0;
    w_space = 1'b0;
    w_push  = 1'b0;
    w_drop  = 1'b0;
    w_valid = (r_count != {(PTR_BITS+1){1'b0}});
    w_pop   = w_valid && m_ready;
    w_dup   = (DEDUP != 0) && r_have_last && (r_x_io == r_last_x) && (r_y_io == r_last_y);
    w_space = (r_count < DEPTH_C) || w_pop;
    if (r_s1_valid && !w_dup) begin
      w_push = w_space;
      w_drop = !w_space;
    end else begin
      w_push = 1'b0;
      w_drop = 1'b0;
    end
  end

  // Last-pushed point; re-enabling forgets it so the first new sample always pushes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_x    <= {ADC_DATA_BITS{1'b0}};
      r_last_y    <= {ADC_DATA_BITS{1'b0}};
      r_have_last <= 1'b0;
    end else if (w_push) begin
      r_last_x    <= r_x_io;
      r_last_y    <= r_y_io;
      r_have_last <= 1'b1;
    end else if (enable && !r_s1_valid) begin
      r_have_last <= 1'b0;
    end else begin
      r_have_last <= r_have_last;
    end
  end

  // Point FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_x[i] <= {ADC_DATA_BITS{1'b0}};
        r_mem_y[i] <= {ADC_DATA_BITS{1'b0}};
      end
      r_wr_ptr <= {PTR_BITS{1'b0}};
      r_rd_ptr <= {PTR_BITS{1'b0}};
      r_count  <= {(PTR_BITS+1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem_x[r_wr_ptr] <= r_x_io;
        r_mem_y[r_wr_ptr] <= r_y_io;
        r_wr_ptr          <= r_wr_ptr + PTR_BITS'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
        2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop statistics; a drop in the clearing cycle leaves a count of one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dropped  <= {DROP_CNT_BITS{1'b0}};
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_stats) begin
        r_dropped <= DROP_CNT_BITS'(1);
      end else if (r_dropped != CNT_MAX) begin
        r_dropped <= r_dropped + DROP_CNT_BITS'(1);
      end else begin
        r_dropped <= r_dropped;
      end
    end else if (clr_stats) begin
      r_dropped  <= {DROP_CNT_BITS{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_dropped  <= r_dropped;
      r_overflow <= r_overflow;
    end
  end

  // Output stream: head entry shown ahead of the handshake
  always_comb begin
    m_valid     = w_valid;
    m_x         = r_mem_x[r_rd_ptr];
    m_y         = r_mem_y[r_rd_ptr];
    dropped_cnt = r_dropped;
    overflow    = r_overflow;
  end

endmodule

// File: tb/tb_adc_xy_sample_stream.sv
// Bench for adc_xy_sample_stream: two instances (DEDUP=1 and DEDUP=0) share stimulus and
// are checked every cycle against a queue-level model plus hand-computed expectations.
module tb_adc_xy_sample_stream;
  localparam int W  = 10;
  localparam int D  = 4;
  localparam int CB = 16;
  localparam int CMAX = 65535;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic clr_stats = 1'b0;
  logic m_ready = 1'b0;
  logic [W-1:0] adc_x = 10'h000;
  logic [W-1:0] adc_y = 10'h000;

  logic mv0, mv1, ov0, ov1;
  logic [W-1:0] mx0, my0, mx1, my1;
  logic [CB-1:0] dc0, dc1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adc_xy_sample_stream #(.ADC_DATA_BITS(W), .FIFO_DEPTH(D), .DEDUP(1), .DROP_CNT_BITS(CB)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_x_io(adc_x), .adc_y_io(adc_y),
    .clr_stats(clr_stats), .m_valid(mv0), .m_ready(m_ready), .m_x(mx0), .m_y(my0),
    .dropped_cnt(dc0), .overflow(ov0));

  adc_xy_sample_stream #(.ADC_DATA_BITS(W), .FIFO_DEPTH(D), .DEDUP(0), .DROP_CNT_BITS(CB)) dut_nd (
    .clk(clk), .reset_n(reset_n), .enable(enable), .adc_x_io(adc_x), .adc_y_io(adc_y),
    .clr_stats(clr_stats), .m_valid(mv1), .m_ready(m_ready), .m_x(mx1), .m_y(my1),
    .dropped_cnt(dc1), .overflow(ov1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: index 0 mirrors the DEDUP=1 instance, index 1 the DEDUP=0 instance
  logic [2*W-1:0] mq [2][D];
  int             mn [2];
  logic [2*W-1:0] m_last [2];
  logic           m_hl [2];
  int             m_cnt [2];
  logic           m_ovf [2];
  logic [2*W-1:0] m_s1;
  logic           m_s1v;
  logic [2*W-1:0] log0 [$];
  logic [2*W-1:0] log1 [$];

  logic           a_mv [2];
  logic [W-1:0]   a_mx [2];
  logic [W-1:0]   a_my [2];
  logic [CB-1:0]  a_dc [2];
  logic           a_ov [2];
  assign a_mv[0] = mv0; assign a_mv[1] = mv1;
  assign a_mx[0] = mx0; assign a_mx[1] = mx1;
  assign a_my[0] = my0; assign a_my[1] = my1;
  assign a_dc[0] = dc0; assign a_dc[1] = dc1;
  assign a_ov[0] = ov0; assign a_ov[1] = ov1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        mn[k] = 0; m_hl[k] = 1'b0; m_cnt[k] = 0; m_ovf[k] = 1'b0; m_last[k] = '0;
      end
      m_s1 = '0;
      m_s1v = 1'b0;
    end else begin
      if (mv0 && m_ready) log0.push_back({mx0, my0});
      if (mv1 && m_ready) log1.push_back({mx1, my1});
      for (int k = 0; k < 2; k++) begin
        if (mn[k] != 0 && m_ready) begin
          for (int i = 0; i < D - 1; i++) mq[k][i] = mq[k][i+1];
          mn[k]--;
        end
        if (clr_stats) begin
          m_cnt[k] = 0;
          m_ovf[k] = 1'b0;
        end
        if (m_s1v) begin
          if (!((k == 0) && m_hl[k] && m_s1 == m_last[k])) begin
            if (mn[k] < D) begin
              mq[k][mn[k]] = m_s1;
              mn[k]++;
              m_last[k] = m_s1;
              m_hl[k] = 1'b1;
            end else begin
              if (m_cnt[k] < CMAX) m_cnt[k]++;
              m_ovf[k] = 1'b1;
            end
          end
        end else if (enable) begin
          m_hl[k] = 1'b0;
        end
      end
      m_s1 = {adc_x, adc_y};
      m_s1v = enable;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cyc_m_valid%0d", k), a_mv[k], (mn[k] != 0));
      if (mn[k] != 0) chk($sformatf("cyc_head%0d", k), {a_mx[k], a_my[k]}, mq[k][0]);
      chk($sformatf("cyc_dropped%0d", k), a_dc[k], m_cnt[k]);
      chk($sformatf("cyc_overflow%0d", k), a_ov[k], m_ovf[k]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_log(input string name, input int which, input int idx, input logic [2*W-1:0] exp);
    logic [2*W-1:0] v;
    int sz;
    sz = (which == 0) ? log0.size() : log1.size();
    if (idx < sz) v = (which == 0) ? log0[idx] : log1[idx];
    else v = 20'hFFFFF;
    chk(name, v, exp);
  endtask

  logic [2*W-1:0] seq2 [5];
  logic [2*W-1:0] exp2 [3];
  logic [2*W-1:0] exp4 [5];
  int base;

  initial begin
    seq2 = '{{10'd1, 10'd1}, {10'd1, 10'd1}, {10'd2, 10'd1}, {10'd2, 10'd1}, {10'd1, 10'd1}};
    exp2 = '{{10'd1, 10'd1}, {10'd2, 10'd1}, {10'd1, 10'd1}};
    exp4 = '{{10'd0, 10'd0}, {10'd1, 10'd0}, {10'd2, 10'd0}, {10'd3, 10'd0}, {10'h055, 10'd0}};

    // Reset state
    cyc(2);
    chk("rst_m_valid", mv0, 32'd0);
    chk("rst_m_x", mx0, 32'd0);
    chk("rst_m_y", my0, 32'd0);
    chk("rst_dropped", dc0, 32'd0);
    chk("rst_overflow", ov1, 32'd0);
    reset_n = 1'b1;
    cyc(1);

    // Two-cycle latency, constant pins give a single point
    base = log0.size();
    enable = 1'b1; m_ready = 1'b1; adc_x = 10'h123; adc_y = 10'h045;
    cyc(1);
    chk("lat_1cyc_m_valid", mv0, 32'd0);
    cyc(1);
    chk("lat_2cyc_m_valid", mv0, 32'd1);
    chk("lat_2cyc_m_x", mx0, 32'h123);
    chk("lat_2cyc_m_y", my0, 32'h045);
    cyc(6);
    enable = 1'b0;
    cyc(4);
    chk("const_points", log0.size() - base, 32'd1);
    chk_log("const_point", 0, base, {10'h123, 10'h045});

    // Dedup pattern
    base = log0.size();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {adc_x, adc_y} = seq2[i];
      cyc(1);
    end
    enable = 1'b0;
    cyc(5);
    chk("dedup_count", log0.size() - base, 32'd3);
    for (int i = 0; i < 3; i++) chk_log($sformatf("dedup_seq%0d", i), 0, base + i, exp2[i]);
    chk("dedup_dropped", dc0, 32'd0);

    // Ramp into stalled FIFO
    base = log1.size();
    m_ready = 1'b0; enable = 1'b1; adc_y = 10'h000;
    for (int i = 0; i < 10; i++) begin
      adc_x = 10'(i);
      cyc(1);
    end
    enable = 1'b0;
    cyc(3);
    chk("ramp_dropped", dc1, 32'd6);
    chk("ramp_overflow", ov1, 32'd1);
    chk("ramp_head", mx1, 32'd0);
    chk("ramp_dropped_dedup", dc0, 32'd6);

    // Full FIFO with a one-cycle pop coinciding with a new sample
    enable = 1'b1; adc_x = 10'h055;
    cyc(1);
    enable = 1'b0; m_ready = 1'b1;
    cyc(1);
    m_ready = 1'b0;
    chk("fullpop_head", mx1, 32'd1);
    chk("fullpop_dropped", dc1, 32'd6);
    m_ready = 1'b1;
    cyc(6);
    chk("drain_m_valid", mv1, 32'd0);
    chk("drain_count", log1.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) chk_log($sformatf("drain_seq%0d", i), 1, base + i, exp4[i]);

    // Saturation and clear-with-drop
    clr_stats = 1'b1;
    cyc(1);
    clr_stats = 1'b0;
    chk("clr_dropped", dc1, 32'd0);
    chk("clr_overflow", ov1, 32'd0);
    m_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 65545; i++) begin
      {adc_y, adc_x} = 20'(i);
      cyc(1);
    end
    chk("sat_dropped", dc0, 32'hFFFF);
    chk("sat_dropped_nd", dc1, 32'hFFFF);
    chk("sat_overflow", ov0, 32'd1);
    clr_stats = 1'b1; enable = 1'b0;
    cyc(1);
    clr_stats = 1'b0;
    chk("clrdrop_dropped", dc0, 32'd1);
    chk("clrdrop_overflow", ov0, 32'd1);
    cyc(2);
    chk("clrdrop_hold", dc1, 32'd1);

    // Async reset mid-stream, then identical point pushes again
    m_ready = 1'b1;
    cyc(6);
    m_ready = 1'b0; enable = 1'b1; adc_y = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      adc_x = 10'h200 + 10'(i);
      cyc(1);
    end
    enable = 1'b0;
    cyc(3);
    chk("pre_rst_m_valid", mv0, 32'd1);
    chk("pre_rst_head", mx0, 32'h200);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_m_valid", mv0, 32'd0);
    chk("async_rst_m_valid_nd", mv1, 32'd0);
    chk("async_rst_dropped", dc0, 32'd0);
    cyc(1);
    reset_n = 1'b1;
    base = log0.size();
    enable = 1'b1;
    cyc(2);
    chk("post_rst_m_valid", mv0, 32'd1);
    chk("post_rst_m_x", mx0, 32'h202);
    chk("post_rst_m_y", my0, 32'h3FF);
    cyc(3);
    enable = 1'b0;
    m_ready = 1'b1;
    cyc(4);
    chk("post_rst_points", log0.size() - base, 32'd1);
    chk("post_rst_empty", mv0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
